// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the multicycle MIPS control
//                unit: opcode and funct encodings, ALU-op type, FSM states.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU operation class handed from the FSM to the ALU decoder
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } statetype_t;

endpackage
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// ============================================================================
//  Module      : aludec
//  Description : Combinational ALU decoder. Maps the FSM's ALU-op class and
//                the R-type funct field to a 3-bit ALU control code.
//  Ports       : aluop      in  2  operation class from the FSM
//                funct      in  6  instr[5:0]
//                alucontrol out 3  ALU operation code
//  Revision    : 1.0  initial release
// ============================================================================
module aludec
    import mips_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        // Add is the safe fallback for every unused code so no x escapes.
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Multicycle MIPS control unit. Moore FSM sequencing lw, sw,
//                R-type, beq, bne, addi and j through the shared datapath.
//  Ports       : clk, reset (async, active-high)
//                op, funct  in  6  IR fields;  zero in 1  ALU zero flag
//                pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//                alusrca    out 1  datapath enables/selects
//                alusrcb, pcsrc out 2;  alucontrol out 3
//  Revision    : 1.0  initial release
// ============================================================================
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    statetype_t state_q;
    statetype_t state_d;

    logic   pcwrite;
    logic   branch;
    logic   branchne;
    aluop_t aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;

        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYPE:       state_d = EXECUTE;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:        state_d = ADDIEXEC;
                    OP_J:           state_d = JUMP;
                    default:        state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW) begin
                    state_d = MEMRD;
                end else if (op == OP_SW) begin
                    state_d = MEMWR;
                end
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = 2'b01;
                branch   = (op == OP_BEQ);
                branchne = (op == OP_BNE);
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                // Unused encodings drive nothing and fall back to FETCH.
                state_d = FETCH;
            end
        endcase
    end

    // Branch resolution uses the live zero flag from the ALU this cycle.
    assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Scoreboard bench for mc_controller. Each driven cycle pushes
//                the expected output vector, derived from an instruction
//                timeline model; a monitor pops and compares mid-cycle.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_controller;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } out_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    out_t exp_q[$];
    bit   done   = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: instruction timelines ----------------
    function automatic int n_cycles(input logic [5:0] o);
        case (o)
            6'b100011:           return 5;  // lw
            6'b101011:           return 4;  // sw
            6'b000000, 6'b001000: return 4; // R-type, addi
            6'b000100, 6'b000101, 6'b000010: return 3; // beq, bne, j
            default:             return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010; // add
            6'b100010: return 3'b110; // sub
            6'b100100: return 3'b000; // and
            6'b100101: return 3'b001; // or
            6'b101010: return 3'b111; // slt
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction (k=0 is the fetch cycle).
    function automatic out_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input int k);
        out_t v;
        v = '0;
        v.alucontrol = 3'b010;
        if (k == 0) begin
            v.irwrite = 1; v.pcen = 1; v.alusrcb = 2'b01;
        end else if (k == 1) begin
            v.alusrcb = 2'b11;
        end else begin
            case (o)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin v.alusrca = 1; v.alusrcb = 2'b10; end
                    else if (k == 3) begin
                        v.iord = 1;
                        v.memwrite = (o == 6'b101011);
                    end else begin
                        v.memtoreg = 1; v.regwrite = 1;
                    end
                end
                6'b000000: begin
                    if (k == 2) begin v.alusrca = 1; v.alucontrol = alu_of_funct(f); end
                    else begin v.regdst = 1; v.regwrite = 1; end
                end
                6'b001000: begin
                    if (k == 2) begin v.alusrca = 1; v.alusrcb = 2'b10; end
                    else v.regwrite = 1;
                end
                6'b000100, 6'b000101: begin
                    v.alusrca = 1; v.pcsrc = 2'b01; v.alucontrol = 3'b110;
                    v.pcen = (o == 6'b000100) ? z : ~z;
                end
                6'b000010: begin
                    v.pcsrc = 2'b10; v.pcen = 1;
                end
                default: v = v;
            endcase
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input out_t e);
        @(posedge clk);
        #1;
        reset = r; op = o; funct = f; zero = z;
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int forced_zero);
        logic z;
        for (int k = 0; k < n_cycles(o); k++) begin
            z = (forced_zero < 0) ? 1'($urandom_range(0, 1)) : 1'(forced_zero);
            drive(1'b0, o, f, z, model(o, f, z, k));
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        out_t got, want;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                        alusrca, alusrcb, pcsrc, alucontrol};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outvec cyc%0d op=%b funct=%b zero=%b got=%b want=%b",
                             cyc, op, funct, zero, got, want);
                end
            end
        end
    end

    logic [5:0] ops [8];
    logic [5:0] fns [5];

    initial begin : stim
        out_t fetch_v;
        logic [5:0] o, f;
        fetch_v = model(6'b0, 6'b0, 1'b0, 0);
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        // Outputs while reset is held are the fetch vector.
        drive(1'b1, 6'b100011, 6'b0, 1'b1, fetch_v);
        drive(1'b1, 6'b100011, 6'b0, 1'b0, fetch_v);

        // lw interrupted by reset in MEMRD
        for (int k = 0; k < 3; k++)
            drive(1'b0, 6'b100011, 6'b0, 1'b0, model(6'b100011, 6'b0, 1'b0, k));
        drive(1'b1, 6'b100011, 6'b0, 1'b0, fetch_v);
        drive(1'b1, 6'b100011, 6'b0, 1'b0, fetch_v);

        // Directed cases
        run_instr(6'b100011, 6'b0, -1);          // lw
        run_instr(6'b000100, 6'b0, 1);           // beq taken
        run_instr(6'b000100, 6'b0, 0);           // beq not taken
        run_instr(6'b000101, 6'b0, 0);           // bne taken
        run_instr(6'b000101, 6'b0, 1);           // bne not taken
        run_instr(6'b000000, 6'b101010, -1);     // slt
        run_instr(6'b000000, 6'b000000, -1);     // unsupported funct
        run_instr(6'b111111, 6'b0, 1);           // unsupported op
        run_instr(6'b101011, 6'b0, -1);          // sw
        run_instr(6'b001000, 6'b0, -1);          // addi
        run_instr(6'b000010, 6'b0, -1);          // j

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(o, f, -1);
        end

        // Let the monitor drain, bounded.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: the other end of the shared multicycle datapath (PC/IR enable flops, register file, ALU, muxes).
- Sequences each instruction through a Moore FSM.
- Drives every datapath select and enable; samples opcode, funct and the ALU zero flag.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi and j.

Parameters:
- none; opcode, funct and state encodings are fixed constants in the shared package.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  6  instr[31:26] from the IR
- funct  input  6  instr[5:0] from the IR
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC register enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  IR enable
- regdst  output  1  write address select: 0 = rt, 1 = rd
- memtoreg  output  1  write data select: 0 = ALUOut, 1 = Data register
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU operation code

Behaviour:
- State register
  - One state register; async reset to FETCH, otherwise updates on the rising clk edge.
  - Reset asserted mid-instruction abandons that instruction immediately.
  - First cycle after reset release is FETCH.
- Output decode
  - All outputs except pcen and alucontrol are purely state-decoded (Moore).
  - Any output not listed for a state is 0.
  - While reset is held, outputs equal the FETCH vector.
- States, asserted outputs and next state:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00 -> DECODE
  - DECODE: alusrcb=11, aluop=00 -> by op:
    - lw/sw -> MEMADR
    - R-type (000000) -> EXECUTE
    - beq (000100) / bne (000101) -> BRANCH
    - addi (001000) -> ADDIEXEC
    - j (000010) -> JUMP
    - any other op -> FETCH (treated as nop, no side effects)
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 -> MEMRD if lw (100011), MEMWR if sw (101011)
  - MEMRD: iord=1 -> MEMWB
  - MEMWB: memtoreg=1, regwrite=1 -> FETCH
  - MEMWR: iord=1, memwrite=1 -> FETCH
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB
  - ALUWB: regdst=1, regwrite=1 -> FETCH
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 for beq, branchne=1 for bne -> FETCH
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB
  - ADDIWB: regwrite=1 -> FETCH
  - JUMP: pcsrc=10, pcwrite=1 -> FETCH
- pcen = pcwrite | (branch & zero) | (branchne & ~zero). Combinational on zero, valid in the same cycle.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, unsupported op 2.
- ALU decode
  - aluop 00 -> 010 (add); 01 -> 110 (sub).
  - aluop 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unsupported funct -> 010. No x is ever driven.
  - aluop 11 is unused -> 010.
- Illegal state encodings return to FETCH on the next edge.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - aluop_t (2-bit typedef) and statetype_t (4-bit enum, FETCH = 0)
- One sub-module, aludec: aluop and funct in, alucontrol out, purely combinational.
- The FSM, output decode and pcen logic stay in mc_controller.

Test Plan:
- Assert reset mid-MEMRD, release -> state FETCH immediately; outputs irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 (lw) from reset -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; iord=1 only in MEMRD; regwrite=1 with memtoreg=1 only in MEMWB; total 5 cycles.
- op=000100 (beq) -> in BRANCH: zero=1 gives pcen=1, pcsrc=01, alucontrol=110; zero=0 gives pcen=0; back to FETCH after 3 cycles.
- op=000101 (bne) -> in BRANCH: zero=0 gives pcen=1; zero=1 gives pcen=0.
- op=000000, funct=101010 (slt) -> EXECUTE drives alucontrol=111; ALUWB drives regdst=1, regwrite=1. funct=000000 -> alucontrol=010.
- op=111111 (unsupported) -> FETCH, DECODE, FETCH; memwrite, regwrite and pcen are never asserted outside FETCH.
